// File: rtl/bomb_game_ctrl_if.sv
// -----------------------------------------------------------------------------
// bomb_game_ctrl_if
// Link between the game controller and the Cronometer.
//   cron_start : controller -> Cronometer, one-cycle start pulse
//   cron_reset : controller -> Cronometer, one-cycle reload pulse
//   game_won   : controller -> Cronometer, level, freezes the display
//   time_over  : Cronometer -> controller, level, countdown expired
// Modports: master = controller side, slave = Cronometer side.
// -----------------------------------------------------------------------------
interface bomb_game_ctrl_if;
    logic cron_start;
    logic cron_reset;
    logic game_won;
    logic time_over;

    modport master (
        output cron_start,
        output cron_reset,
        output game_won,
        input  time_over
    );

    modport slave (
        input  cron_start,
        input  cron_reset,
        input  game_won,
        output time_over
    );
endinterface

// File: rtl/bomb_game_ctrl.sv
// -----------------------------------------------------------------------------
// bomb_game_ctrl
// Game sequencer for the time bomb: conditions the pushbuttons, arms the
// Cronometer, checks the defuse code digit by digit and counts strikes.
//
// Ports:
//   clk, reset (sync, active-high)
//   btn_start, btn_digit[3:0] : raw asynchronous button levels
//   tick_1s                   : one-cycle pulse per second
//   cron                      : Cronometer link (cron_start/cron_reset/
//                               game_won out, time_over in)
//   exploded, alarm           : indicator levels
//   strikes[1:0], code_pos[2:0], state[2:0] : game status
//
// Optional feature macro: STRIKE_LOCKOUT_EN -- after a non-fatal wrong digit,
// digit presses are discarded for LOCKOUT_TICKS seconds and alarm is held high.
// -----------------------------------------------------------------------------
module bomb_game_ctrl #(
    parameter int          CODE_LEN      = 4,
    parameter logic [15:0] CODE          = 16'b11_10_01_00,
    parameter int          MAX_STRIKES   = 3,
    parameter int          LOCKOUT_TICKS = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    btn_start,
    input  logic [3:0]              btn_digit,
    input  logic                    tick_1s,
    bomb_game_ctrl_if.master        cron,
    output logic                    exploded,
    output logic                    alarm,
    output logic [1:0]              strikes,
    output logic [2:0]              code_pos,
    output logic [2:0]              state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RUNNING  = 3'd1,
        S_DEFUSED  = 3'd2,
        S_EXPLODED = 3'd3
    } state_e;

    // Button synchronizers and previous-value flops for edge detection
    logic       start_meta_q, start_sync_q, start_prev_q;
    logic [3:0] dig_meta_q, dig_sync_q, dig_prev_q;

    // Game state
    state_e     state_q, state_d;
    logic [1:0] strikes_q, strikes_d;
    // One extra bit so the counter can hold CODE_LEN=8 internally
    logic [3:0] code_pos_q, code_pos_d;
    logic       alarm_q, alarm_d;
    logic       cron_start_q, cron_start_d;
    logic       cron_reset_q, cron_reset_d;
    logic       game_won_q, game_won_d;
    logic       exploded_q, exploded_d;

    logic       start_press_s;
    logic [3:0] dig_rise_s;
    logic       dig_event_s;
    logic       dig_single_s;
    logic [1:0] dig_val_s;
    logic [1:0] code_digit_s;
    logic [1:0] strikes_inc_s;
    logic       dig_accept_s;

`ifdef STRIKE_LOCKOUT_EN
    logic [7:0] lock_q, lock_d;
`endif

    // Two-flop synchronizers followed by the edge-detector history flops
    always_ff @(posedge clk) begin
        if (reset) begin
            start_meta_q <= 1'b0;
            start_sync_q <= 1'b0;
            start_prev_q <= 1'b0;
            dig_meta_q   <= 4'd0;
            dig_sync_q   <= 4'd0;
            dig_prev_q   <= 4'd0;
        end else begin
            start_meta_q <= btn_start;
            start_sync_q <= start_meta_q;
            start_prev_q <= start_sync_q;
            dig_meta_q   <= btn_digit;
            dig_sync_q   <= dig_meta_q;
            dig_prev_q   <= dig_sync_q;
        end
    end

    // Press events and digit decode
    always_comb begin
        start_press_s = start_sync_q & ~start_prev_q;
        dig_rise_s    = dig_sync_q & ~dig_prev_q;
        dig_event_s   = |dig_rise_s;
        dig_single_s  = $onehot(dig_rise_s);
        case (dig_rise_s)
            4'b0001: dig_val_s = 2'd0;
            4'b0010: dig_val_s = 2'd1;
            4'b0100: dig_val_s = 2'd2;
            4'b1000: dig_val_s = 2'd3;
            default: dig_val_s = 2'd0;
        endcase
        code_digit_s  = CODE[{code_pos_q[2:0], 1'b0} +: 2];
        strikes_inc_s = strikes_q + 2'd1;
`ifdef STRIKE_LOCKOUT_EN
        dig_accept_s  = dig_event_s & (lock_q == 8'd0);
`else
        dig_accept_s  = dig_event_s;
`endif
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        strikes_d    = strikes_q;
        code_pos_d   = code_pos_q;
        alarm_d      = alarm_q;
        cron_start_d = 1'b0;
        cron_reset_d = 1'b0;
`ifdef STRIKE_LOCKOUT_EN
        lock_d       = lock_q;
`endif
        case (state_q)
            S_IDLE: begin
                alarm_d = 1'b0;
                if (start_press_s) begin
                    cron_reset_d = 1'b1;
                    cron_start_d = 1'b1;
                    strikes_d    = 2'd0;
                    code_pos_d   = 4'd0;
                    state_d      = S_RUNNING;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUNNING: begin
                if (tick_1s) begin
                    alarm_d = ~alarm_q;
                end else begin
                    alarm_d = alarm_q;
                end
`ifdef STRIKE_LOCKOUT_EN
                if (tick_1s && (lock_q != 8'd0)) begin
                    lock_d = lock_q - 8'd1;
                end else begin
                    lock_d = lock_q;
                end
`endif
                // Countdown expiry beats any same-cycle digit, even the last one
                if (cron.time_over) begin
                    state_d = S_EXPLODED;
                    alarm_d = 1'b1;
                end else if (dig_accept_s) begin
                    if (dig_single_s && (dig_val_s == code_digit_s)) begin
                        code_pos_d = code_pos_q + 4'd1;
                        if (code_pos_q == 4'(CODE_LEN - 1)) begin
                            state_d = S_DEFUSED;
                            alarm_d = 1'b0;
                        end else begin
                            state_d = S_RUNNING;
                        end
                    end else begin
                        code_pos_d = 4'd0;
                        if (strikes_q != 2'(MAX_STRIKES)) begin
                            strikes_d = strikes_inc_s;
                        end else begin
                            strikes_d = strikes_q;
                        end
                        if (strikes_inc_s == 2'(MAX_STRIKES)) begin
                            state_d = S_EXPLODED;
                            alarm_d = 1'b1;
                        end else begin
`ifdef STRIKE_LOCKOUT_EN
                            lock_d = 8'(LOCKOUT_TICKS);
`endif
                            state_d = S_RUNNING;
                        end
                    end
                end else begin
                    state_d = S_RUNNING;
                end
            end
            S_DEFUSED: begin
                alarm_d = 1'b0;
                if (start_press_s) begin
                    cron_reset_d = 1'b1;
                    strikes_d    = 2'd0;
                    code_pos_d   = 4'd0;
                    state_d      = S_IDLE;
                end else begin
                    state_d = S_DEFUSED;
                end
            end
            S_EXPLODED: begin
                if (start_press_s) begin
                    cron_reset_d = 1'b1;
                    strikes_d    = 2'd0;
                    code_pos_d   = 4'd0;
                    alarm_d      = 1'b0;
                    state_d      = S_IDLE;
                end else begin
                    alarm_d = 1'b1;
                    state_d = S_EXPLODED;
                end
            end
            default: begin
                state_d    = S_IDLE;
                strikes_d  = 2'd0;
                code_pos_d = 4'd0;
                alarm_d    = 1'b0;
            end
        endcase
`ifdef STRIKE_LOCKOUT_EN
        // Lockout only lives inside RUNNING; it also pins the alarm high
        if (state_d != S_RUNNING) begin
            lock_d = 8'd0;
        end else if (lock_d != 8'd0) begin
            alarm_d = 1'b1;
        end else begin
            lock_d = lock_d;
        end
`endif
        game_won_d = (state_d == S_DEFUSED);
        exploded_d = (state_d == S_EXPLODED);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            strikes_q    <= 2'd0;
            code_pos_q   <= 4'd0;
            alarm_q      <= 1'b0;
            cron_start_q <= 1'b0;
            cron_reset_q <= 1'b0;
            game_won_q   <= 1'b0;
            exploded_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            strikes_q    <= strikes_d;
            code_pos_q   <= code_pos_d;
            alarm_q      <= alarm_d;
            cron_start_q <= cron_start_d;
            cron_reset_q <= cron_reset_d;
            game_won_q   <= game_won_d;
            exploded_q   <= exploded_d;
        end
    end

`ifdef STRIKE_LOCKOUT_EN
    // Lockout countdown register
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_q <= 8'd0;
        end else begin
            lock_q <= lock_d;
        end
    end
`endif

    assign cron.cron_start = cron_start_q;
    assign cron.cron_reset = cron_reset_q;
    assign cron.game_won   = game_won_q;
    assign exploded        = exploded_q;
    assign alarm           = alarm_q;
    assign strikes         = strikes_q;
    assign code_pos        = code_pos_q[2:0];
    assign state           = state_q;

endmodule

// File: tb/tb_bomb_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bomb_game_ctrl
// Directed bench for bomb_game_ctrl with the default parameters
// (CODE digits 0,1,2,3; three strikes). Outputs are sampled 1 time unit
// after the rising edge.
// -----------------------------------------------------------------------------
module tb_bomb_game_ctrl;
    logic       clk;
    logic       reset;
    logic       btn_start;
    logic [3:0] btn_digit;
    logic       tick_1s;
    logic       exploded;
    logic       alarm;
    logic [1:0] strikes;
    logic [2:0] code_pos;
    logic [2:0] state;

    int n_total;
    int n_pass;

    bomb_game_ctrl_if cron_if ();

    bomb_game_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .btn_start (btn_start),
        .btn_digit (btn_digit),
        .tick_1s   (tick_1s),
        .cron      (cron_if),
        .exploded  (exploded),
        .alarm     (alarm),
        .strikes   (strikes),
        .code_pos  (code_pos),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Start press: pulse lands on the third edge after the button goes high
    task automatic press_start(input logic exp_start, input logic [2:0] exp_state);
        btn_start = 1'b1;
        step(2);
        chk("start_early_reset", 32'(cron_if.cron_reset), 32'd0);
        step(1);
        chk("start_cron_reset", 32'(cron_if.cron_reset), 32'd1);
        chk("start_cron_start", 32'(cron_if.cron_start), 32'(exp_start));
        chk("start_state", 32'(state), 32'(exp_state));
        step(1);
        chk("start_reset_1cyc", 32'(cron_if.cron_reset), 32'd0);
        chk("start_start_1cyc", 32'(cron_if.cron_start), 32'd0);
        btn_start = 1'b0;
        step(3);
    endtask

    task automatic press_digit(input logic [3:0] mask);
        btn_digit = mask;
        step(3);
        btn_digit = 4'd0;
        step(3);
    endtask

    task automatic pulse_tick();
        tick_1s = 1'b1;
        step(1);
        tick_1s = 1'b0;
        step(1);
    endtask

    task automatic pulse_time_over();
        cron_if.time_over = 1'b1;
        step(1);
        cron_if.time_over = 1'b0;
        step(1);
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        reset = 1'b1;
        btn_start = 1'b0;
        btn_digit = 4'd0;
        tick_1s = 1'b0;
        cron_if.time_over = 1'b0;
        step(3);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_strikes", 32'(strikes), 32'd0);
        chk("rst_code_pos", 32'(code_pos), 32'd0);
        chk("rst_alarm", 32'(alarm), 32'd0);
        chk("rst_cron_start", 32'(cron_if.cron_start), 32'd0);
        chk("rst_game_won", 32'(cron_if.game_won), 32'd0);
        chk("rst_exploded", 32'(exploded), 32'd0);
        reset = 1'b0;
        step(2);

        // Digits are ignored while idle
        press_digit(4'b0001);
        chk("idle_digit_pos", 32'(code_pos), 32'd0);
        chk("idle_digit_state", 32'(state), 32'd0);

        // Game 1: correct code -> DEFUSED
        press_start(1'b1, 3'd1);
        chk("g1_strikes", 32'(strikes), 32'd0);
        chk("g1_code_pos", 32'(code_pos), 32'd0);
        chk("g1_alarm0", 32'(alarm), 32'd0);
        pulse_tick();
        chk("g1_alarm_tick1", 32'(alarm), 32'd1);
        pulse_tick();
        chk("g1_alarm_tick2", 32'(alarm), 32'd0);
        press_digit(4'b0001);
        chk("g1_pos1", 32'(code_pos), 32'd1);
        press_digit(4'b0010);
        chk("g1_pos2", 32'(code_pos), 32'd2);
        press_digit(4'b0100);
        chk("g1_pos3", 32'(code_pos), 32'd3);
        press_digit(4'b1000);
        chk("g1_pos4", 32'(code_pos), 32'd4);
        chk("g1_state_defused", 32'(state), 32'd2);
        chk("g1_game_won", 32'(cron_if.game_won), 32'd1);
        press_digit(4'b0001);
        chk("g1_pos_sat", 32'(code_pos), 32'd4);
        pulse_time_over();
        chk("g1_time_over_ignored", 32'(state), 32'd2);
        press_start(1'b0, 3'd0);
        chk("g1_exit_pos", 32'(code_pos), 32'd0);
        chk("g1_exit_won", 32'(cron_if.game_won), 32'd0);

        // Game 2: three wrong digits -> EXPLODED
        press_start(1'b1, 3'd1);
        press_digit(4'b0001);
        chk("g2_pos1", 32'(code_pos), 32'd1);
        press_digit(4'b0100);
        chk("g2_wrong_pos", 32'(code_pos), 32'd0);
        chk("g2_strikes1", 32'(strikes), 32'd1);
        pulse_tick();
        pulse_tick();
        press_digit(4'b1000);
        chk("g2_strikes2", 32'(strikes), 32'd2);
        pulse_tick();
        pulse_tick();
        press_digit(4'b1000);
        chk("g2_strikes3", 32'(strikes), 32'd3);
        chk("g2_state_exploded", 32'(state), 32'd3);
        chk("g2_exploded", 32'(exploded), 32'd1);
        chk("g2_alarm", 32'(alarm), 32'd1);
        pulse_tick();
        chk("g2_alarm_steady", 32'(alarm), 32'd1);
        press_start(1'b0, 3'd0);
        chk("g2_exit_strikes", 32'(strikes), 32'd0);
        chk("g2_exit_alarm", 32'(alarm), 32'd0);
        chk("g2_exit_exploded", 32'(exploded), 32'd0);

        // Game 3: time_over coincides with the final correct digit
        press_start(1'b1, 3'd1);
        press_digit(4'b0001);
        press_digit(4'b0010);
        press_digit(4'b0100);
        chk("g3_pos3", 32'(code_pos), 32'd3);
        btn_digit = 4'b1000;
        step(2);
        cron_if.time_over = 1'b1;
        step(1);
        cron_if.time_over = 1'b0;
        chk("g3_priority_state", 32'(state), 32'd3);
        chk("g3_priority_won", 32'(cron_if.game_won), 32'd0);
        btn_digit = 4'd0;
        step(3);
        press_start(1'b0, 3'd0);
        chk("g3_exit_pos", 32'(code_pos), 32'd0);
        chk("g3_exit_strikes", 32'(strikes), 32'd0);

        // Game 4: simultaneous digits, then a long hold
        press_start(1'b1, 3'd1);
        press_digit(4'b0110);
        chk("g4_multi_strikes", 32'(strikes), 32'd1);
        chk("g4_multi_pos", 32'(code_pos), 32'd0);
        pulse_tick();
        pulse_tick();
        btn_digit = 4'b0001;
        step(1000);
        btn_digit = 4'd0;
        step(3);
        chk("g4_hold_pos", 32'(code_pos), 32'd1);
        chk("g4_hold_strikes", 32'(strikes), 32'd1);
        pulse_time_over();
        chk("g4_time_over", 32'(state), 32'd3);
        press_start(1'b0, 3'd0);

`ifdef STRIKE_LOCKOUT_EN
        // Game 5: lockout after a wrong digit
        press_start(1'b1, 3'd1);
        press_digit(4'b0010);
        chk("g5_strikes1", 32'(strikes), 32'd1);
        chk("g5_lock_alarm", 32'(alarm), 32'd1);
        press_digit(4'b0001);
        chk("g5_locked_pos", 32'(code_pos), 32'd0);
        chk("g5_locked_strikes", 32'(strikes), 32'd1);
        pulse_tick();
        pulse_tick();
        press_digit(4'b0001);
        chk("g5_unlocked_pos", 32'(code_pos), 32'd1);
        chk("g5_unlocked_strikes", 32'(strikes), 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/bomb_game_ctrl.md
Name: bomb_game_ctrl

Overview:
- Game-sequencing controller for the time-bomb design.
- Sits between the player pushbuttons and the Cronometer: arms the countdown, accepts a defuse code and counts strikes.
- Drives the Cronometer's start, reset and game_won inputs and consumes its time_over output.
- Also consumes tick_1s from Freq_Div_1Hz for the alarm and lockout timing.

Parameters:
- CODE_LEN, 4, number of digits in the defuse code (1..8).
- CODE, 16'b11_10_01_00, secret code; digit i is CODE[2i+1:2i]; digit 0 is entered first; only the low 2*CODE_LEN bits are used.
- MAX_STRIKES, 3, wrong digits that cause explosion (1..3).
- LOCKOUT_TICKS, 2, tick_1s periods of input lockout after a strike (used only with the optional feature).

Ports:
- clk  in  1  system clock (CLOCK_50 domain)
- reset  in  1  synchronous, active-high reset
- btn_start  in  1  start/restart button, active-high level, asynchronous to clk
- btn_digit  in  4  digit buttons 0..3, active-high levels, asynchronous to clk
- tick_1s  in  1  one-cycle pulse per second
- time_over  in  1  Cronometer countdown expired (level, clk domain)
- cron_start  out  1  one-cycle pulse that starts the Cronometer
- cron_reset  out  1  one-cycle pulse that reloads the Cronometer
- game_won  out  1  level, high in DEFUSED; drives Cronometer game_won to freeze the display
- exploded  out  1  level, high in EXPLODED
- alarm  out  1  indicator output
- strikes  out  2  wrong digits so far
- code_pos  out  3  digits correctly entered so far
- state  out  3  FSM encoding: IDLE=0, RUNNING=1, DEFUSED=2, EXPLODED=3

Behaviour:
- Reset: reset is synchronous and active-high. While reset is high at a clk edge, all outputs, synchronizers and counters go to 0 and state goes to IDLE. The system reset is ORed into the Cronometer reset at top level.
- Input conditioning:
  - btn_start and each btn_digit bit pass through a 2-flop synchronizer and then a registered rising-edge detector.
  - Press latency: counting the first edge that samples the button high as edge 1, the FSM acts at edge 3 and its registered outputs change at that edge.
  - Holding a button produces exactly one press.
- Digit decode:
  - A press event with exactly one btn_digit bit rising that cycle is valid; the digit value is the bit index.
  - Two or more digit bits rising in the same cycle count as one wrong digit.
- IDLE:
  - Start press: cron_reset and cron_start both pulse for one cycle; strikes and code_pos clear; go to RUNNING.
  - Digit presses are ignored.
- RUNNING:
  - time_over=1: go to EXPLODED. This has priority over any press in the same cycle, including the final correct digit.
  - Digit equal to CODE digit[code_pos]: code_pos increments. If code_pos was CODE_LEN-1, go to DEFUSED and code_pos holds at CODE_LEN.
  - Wrong digit: code_pos clears to 0 and strikes increments. If the new strikes value equals MAX_STRIKES, go to EXPLODED.
  - Start press is ignored.
- DEFUSED:
  - game_won=1.
  - Start press: cron_reset pulses, all counters clear, go to IDLE.
  - time_over is ignored.
- EXPLODED:
  - exploded=1.
  - Start press: same exit as DEFUSED (cron_reset pulse, counters clear, go to IDLE).
- alarm:
  - 0 in IDLE and DEFUSED.
  - In RUNNING, toggles on each tick_1s.
  - In EXPLODED, constant 1.
  - Forced to 0 on entry to IDLE.
- Counter saturation:
  - strikes never exceeds MAX_STRIKES.
  - code_pos never exceeds CODE_LEN.
- cron_start and cron_reset are never high for two consecutive cycles.

Optional Feature:
- Macro: STRIKE_LOCKOUT_EN.
- Defined:
  - A wrong digit that does not cause explosion loads a lockout counter with LOCKOUT_TICKS.
  - The counter decrements on each tick_1s.
  - While it is nonzero, digit presses are discarded (they do not advance code_pos and add no strike), and alarm is held at 1.
  - time_over, and a transition to EXPLODED or IDLE, clear the counter.
- Undefined: there is no lockout counter, and digit presses are accepted every cycle in RUNNING.

Test Plan:
- Reset, then a start press: cron_reset=1 and cron_start=1 for one cycle at edge 3; state=1, strikes=0, code_pos=0.
- In RUNNING, press digits 0,1,2,3 (default CODE): code_pos steps 1,2,3,4; state=2, game_won=1; a later time_over pulse keeps state=2.
- In RUNNING, press 0,2: code_pos=0 and strikes=1. Two more wrong digits give strikes=3, state=3, exploded=1, alarm=1.
- time_over rises in the same cycle as the 4th correct digit's press event: state=3 (not 2); then a start press gives a cron_reset pulse and state=0 with all counters 0.
- Digits 1 and 2 rise in the same cycle: strikes=1. A button held for 1000 cycles counts as a single press.
- With STRIKE_LOCKOUT_EN: wrong digit, then digit 0 pressed before 2 ticks: code_pos=0 and strikes=1 unchanged; after 2 tick_1s pulses, digit 0 gives code_pos=1.
